// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Pops scancode bytes from a ps2_keyboard receive FIFO and
//               tracks the currently held key (scancode, ASCII, held flag),
//               a count of distinct presses, and a sticky FIFO-overflow flag.
//               Understands the 0xE0 extended prefix and 0xF0 break prefix.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data,
    input  logic               ready,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic [7:0]         key_code,
    output logic [7:0]         key_ascii,
    output logic               key_down,
    output logic [COUNT_W-1:0] key_count,
    output logic               ovf_seen
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FETCH  = 2'd1;
    localparam logic [1:0] c_DECODE = 2'd2;

    localparam logic [7:0] c_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] c_BRK_PREFIX = 8'hF0;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_nextdata_n;

    logic [7:0]         r_byte;
    logic               r_ext;
    logic               r_brk;

    logic [7:0]         r_key_code;
    logic [7:0]         r_key_ascii;
    logic               r_key_down;
    logic [COUNT_W-1:0] r_key_count;
    logic               r_ovf_seen;

    logic               w_decode;
    logic               w_is_ext;
    logic               w_is_brk;
    logic               w_same_key;
    logic               w_new_press;
    logic [7:0]         w_ascii_raw;
    logic [7:0]         w_ascii;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Holds the fetch sequencer state; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and pop strobe
    // ------------------------------------------------------------------------
    // IDLE waits for a byte, FETCH pops it (one low cycle), DECODE consumes it.
    // ready is only looked at in IDLE, so a drop during FETCH cannot abort
    // a pop that is already in progress.
    always_comb begin
        w_state_next = r_state;
        w_nextdata_n = 1'b1;
        case (r_state)
            c_IDLE: begin
                if (ready) begin
                    w_state_next = c_FETCH;
                end
            end
            c_FETCH: begin
                w_nextdata_n = 1'b0;
                w_state_next = c_DECODE;
            end
            c_DECODE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    assign nextdata_n = w_nextdata_n;

    // ------------------------------------------------------------------------
    // Byte capture
    // ------------------------------------------------------------------------
    // Latch the FIFO head at the closing edge of FETCH; with rst high in that
    // cycle the byte is dropped and the decoder never sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte <= 8'h00;
        end else if (r_state == c_FETCH) begin
            r_byte <= data;
        end
    end

    // ------------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------------
    assign w_decode    = (r_state == c_DECODE);
    assign w_is_ext    = (r_byte == c_EXT_PREFIX);
    assign w_is_brk    = (r_byte == c_BRK_PREFIX);
    assign w_same_key  = (r_byte == r_key_code);
    // A make code counts as a new press unless it is a typematic repeat of
    // the key already held.
    assign w_new_press = !r_key_down || !w_same_key;

    // ------------------------------------------------------------------------
    // Scancode (set 2) to ASCII table
    // ------------------------------------------------------------------------
    // Letters map to uppercase, digit row to '0'..'9', plus space and enter.
    always_comb begin
        w_ascii_raw = 8'h00;
        case (r_byte)
            8'h1C: w_ascii_raw = 8'h41; // A
            8'h32: w_ascii_raw = 8'h42; // B
            8'h21: w_ascii_raw = 8'h43; // C
            8'h23: w_ascii_raw = 8'h44; // D
            8'h24: w_ascii_raw = 8'h45; // E
            8'h2B: w_ascii_raw = 8'h46; // F
            8'h34: w_ascii_raw = 8'h47; // G
            8'h33: w_ascii_raw = 8'h48; // H
            8'h43: w_ascii_raw = 8'h49; // I
            8'h3B: w_ascii_raw = 8'h4A; // J
            8'h42: w_ascii_raw = 8'h4B; // K
            8'h4B: w_ascii_raw = 8'h4C; // L
            8'h3A: w_ascii_raw = 8'h4D; // M
            8'h31: w_ascii_raw = 8'h4E; // N
            8'h44: w_ascii_raw = 8'h4F; // O
            8'h4D: w_ascii_raw = 8'h50; // P
            8'h15: w_ascii_raw = 8'h51; // Q
            8'h2D: w_ascii_raw = 8'h52; // R
            8'h1B: w_ascii_raw = 8'h53; // S
            8'h2C: w_ascii_raw = 8'h54; // T
            8'h3C: w_ascii_raw = 8'h55; // U
            8'h2A: w_ascii_raw = 8'h56; // V
            8'h1D: w_ascii_raw = 8'h57; // W
            8'h22: w_ascii_raw = 8'h58; // X
            8'h35: w_ascii_raw = 8'h59; // Y
            8'h1A: w_ascii_raw = 8'h5A; // Z
            8'h45: w_ascii_raw = 8'h30; // 0
            8'h16: w_ascii_raw = 8'h31; // 1
            8'h1E: w_ascii_raw = 8'h32; // 2
            8'h26: w_ascii_raw = 8'h33; // 3
            8'h25: w_ascii_raw = 8'h34; // 4
            8'h2E: w_ascii_raw = 8'h35; // 5
            8'h36: w_ascii_raw = 8'h36; // 6
            8'h3D: w_ascii_raw = 8'h37; // 7
            8'h3E: w_ascii_raw = 8'h38; // 8
            8'h46: w_ascii_raw = 8'h39; // 9
            8'h29: w_ascii_raw = 8'h20; // space
            8'h5A: w_ascii_raw = 8'h0D; // enter
            default: w_ascii_raw = 8'h00;
        endcase
    end

    // Extended codes share numbers with ordinary keys, so they never map.
    assign w_ascii = r_ext ? 8'h00 : w_ascii_raw;

    // ------------------------------------------------------------------------
    // Decoder state and key outputs
    // ------------------------------------------------------------------------
    // Prefix bytes only arm ext/brk; a following code is either a release
    // (brk armed) or a make, and both consume the prefixes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ascii <= 8'h00;
            r_key_down  <= 1'b0;
            r_key_count <= '0;
        end else if (w_decode) begin
            if (w_is_ext) begin
                r_ext <= 1'b1;
            end else if (w_is_brk) begin
                r_brk <= 1'b1;
            end else if (r_brk) begin
                // Release: only the held key can be released.
                if (w_same_key) begin
                    r_key_down <= 1'b0;
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else begin
                // Make: load the new key; repeats of the held key are not
                // counted. The counter wraps silently.
                if (w_new_press) begin
                    r_key_count <= r_key_count + COUNT_W'(1);
                end
                r_key_code  <= r_byte;
                r_key_ascii <= w_ascii;
                r_key_down  <= 1'b1;
                r_ext       <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------------
    // Any sampled overflow is remembered until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_seen <= 1'b0;
        end else if (overflow) begin
            r_ovf_seen <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign key_code  = r_key_code;
    assign key_ascii = r_key_ascii;
    assign key_down  = r_key_down;
    assign key_count = r_key_count;
    assign ovf_seen  = r_ovf_seen;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Self-checking bench for ps2_key_decoder. A queue stands in
//               for the ps2_keyboard FIFO; a key-state model applies the
//               scancode rules to every byte pushed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         data = 8'h00;
    logic               ready = 1'b0;
    logic               overflow = 1'b0;
    logic               nextdata_n;
    logic [7:0]         key_code;
    logic [7:0]         key_ascii;
    logic               key_down;
    logic [COUNT_W-1:0] key_count;
    logic               ovf_seen;

    ps2_key_decoder #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ascii  (key_ascii),
        .key_down   (key_down),
        .key_count  (key_count),
        .ovf_seen   (ovf_seen)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    // Stand-in for the keyboard receive FIFO.
    logic [7:0] fifo[$];
    logic       last_nd;

    // Key-state model.
    logic [7:0] ascii_of[logic [7:0]];
    logic [7:0] codes[$];
    logic [7:0] m_code;
    logic [7:0] m_ascii;
    logic       m_down;
    logic       m_ext;
    logic       m_brk;
    int         m_count;
    logic       m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_code = 8'h00; m_ascii = 8'h00; m_down = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_count = 0; m_ovf = 1'b0;
    endtask

    // Scancode rules applied to one byte.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            if (b == m_code) m_down = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            if (!m_down || b != m_code) m_count = (m_count + 1) % (1 << COUNT_W);
            m_code  = b;
            m_ascii = (!m_ext && ascii_of.exists(b)) ? ascii_of[b] : 8'h00;
            m_down  = 1'b1;
            m_ext   = 1'b0;
        end
    endtask

    // One clock: observe the pop strobe mid-cycle, then let the FIFO react.
    task automatic cycle();
        logic pop;
        @(negedge clk);
        pop     = !nextdata_n;
        last_nd = nextdata_n;
        if (overflow && !rst) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        ready = 1'b1;
        data  = fifo[0];
    endtask

    task automatic drain();
        int guard = 0;
        while (fifo.size() != 0 && guard < 5000) begin
            cycle();
            guard++;
        end
        chk("drain_empty", 32'(fifo.size()), 32'd0);
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        fifo.delete();
        ready = 1'b0;
        data  = 8'h00;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_code"},  32'(key_code),  32'(m_code));
        chk({tag, "_ascii"}, 32'(key_ascii), 32'(m_ascii));
        chk({tag, "_down"},  32'(key_down),  32'(m_down));
        chk({tag, "_count"}, 32'(key_count), 32'(m_count));
        chk({tag, "_ovf"},   32'(ovf_seen),  32'(m_ovf));
        chk({tag, "_nd"},    32'(nextdata_n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] letters[26];
        logic [7:0] digits[10];
        logic [7:0] b;
        int         n;
        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) begin
            ascii_of[letters[i]] = 8'(65 + i);
            codes.push_back(letters[i]);
        end
        for (int i = 0; i < 10; i++) begin
            ascii_of[digits[i]] = 8'(48 + i);
            codes.push_back(digits[i]);
        end
        ascii_of[8'h29] = 8'h20; codes.push_back(8'h29);
        ascii_of[8'h5A] = 8'h0D; codes.push_back(8'h5A);
        last_nd = 1'b1;

        // Reset state.
        do_reset();
        check_all("reset");

        // Press and release of 'A'.
        push(8'h1C);
        drain();
        check_all("make_a");
        chk("make_a_ascii_const", 32'(key_ascii), 32'h41);
        push(8'hF0); push(8'h1C);
        drain();
        check_all("break_a");
        chk("break_a_down_const", 32'(key_down), 32'd0);

        // Typematic repeats, then a different key.
        do_reset();
        push(8'h16); push(8'h16); push(8'h16);
        drain();
        check_all("typematic");
        chk("typematic_count_const", 32'(key_count), 32'd1);
        push(8'h1E);
        drain();
        check_all("second_key");

        // Extended key make and break.
        push(8'hE0); push(8'h75);
        drain();
        check_all("ext_make");
        chk("ext_make_ascii_const", 32'(key_ascii), 32'h00);
        push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        check_all("ext_break");

        // Latency and pop cadence with ready held high.
        do_reset();
        for (int i = 0; i < 12; i++) push(codes[$urandom_range(0, codes.size() - 1)]);
        for (int k = 1; k <= 33; k++) begin
            cycle();
            chk($sformatf("cadence_nd_k%0d", k), 32'(last_nd), (k % 3 == 2) ? 32'd1 - 32'd1 : 32'd1);
            if (k == 2) chk("latency_before", 32'(key_down), 32'd0);
            if (k == 3) chk("latency_after", 32'(key_down), 32'd1);
        end
        drain();
        check_all("cadence_end");

        // ready drops during FETCH: the byte is still taken.
        fifo.push_back(8'h29);
        model_byte(8'h29);
        ready = 1'b1;
        data  = 8'h29;
        cycle();
        ready = 1'b0;
        cycle();
        repeat (4) cycle();
        check_all("ready_drop");

        // Randomized byte streams.
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(4, 10);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 9))
                    0:       b = 8'hE0;
                    1:       b = 8'hF0;
                    2, 3:    b = m_code;
                    8, 9: begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'hE0 || b == 8'hF0) b = 8'h00;
                    end
                    default: b = codes[$urandom_range(0, codes.size() - 1)];
                endcase
                push(b);
            end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) cycle();
            drain();
            check_all($sformatf("rand%0d", r));
        end

        // Press counter wrap.
        do_reset();
        for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
        drain();
        check_all("wrap");
        chk("wrap_count_zero", 32'(key_count), 32'd0);

        // Sticky overflow flag.
        overflow = 1'b1;
        cycle();
        overflow = 1'b0;
        repeat (5) cycle();
        chk("ovf_sticky", 32'(ovf_seen), 32'd1);
        push(8'h24);
        drain();
        check_all("ovf_hold");
        do_reset();
        chk("ovf_cleared", 32'(ovf_seen), 32'd0);

        // Reset during the FETCH of a byte discards that byte.
        push(8'h32);
        drain();
        check_all("pre_rst_fetch");
        fifo.push_back(8'h1C);
        ready = 1'b1;
        data  = 8'h1C;
        cycle();
        chk("rst_fetch_nd_low", 32'(nextdata_n), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_reset();
        repeat (4) cycle();
        check_all("rst_fetch");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
